// File: rtl/csel_pkg.sv
// Shared sizing helpers for the pipelined carry-select adder.
//   csel_num_blocks : number of BLOCK-wide carry-select blocks in WIDTH bits
//   csel_num_stages : number of pipeline stages when BPS blocks share a stage
// The CSEL_DEF_* constants describe the default configuration of the top.
package csel_pkg;

  function automatic int csel_num_blocks(input int width, input int block);
    return width / block;
  endfunction

  function automatic int csel_num_stages(input int width, input int block, input int bps);
    return ((width / block) + bps - 1) / bps;
  endfunction

  localparam int CSEL_DEF_WIDTH = 32;
  localparam int CSEL_DEF_BLOCK = 4;
  localparam int CSEL_DEF_BPS   = 2;
  localparam int CSEL_DEF_NB    = csel_num_blocks(CSEL_DEF_WIDTH, CSEL_DEF_BLOCK);
  localparam int CSEL_DEF_NS    = csel_num_stages(CSEL_DEF_WIDTH, CSEL_DEF_BLOCK, CSEL_DEF_BPS);

endpackage

// File: rtl/csel_block.sv
// One carry-select block: both candidate sums (carry-in 0 and carry-in 1)
// are rippled in parallel and the real incoming carry picks one.
// Ports:
//   a, b  : BLOCK-bit operand slices
//   ci    : incoming carry (select)
//   s     : selected sum slice
//   co    : carry out of the block
//   c_msb : carry into the block's top bit (for signed overflow)
module csel_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [BLOCK:0] w_r0;
  logic [BLOCK:0] w_r1;

  assign w_r0 = {1'b0, a} + {1'b0, b};
  assign w_r1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

  assign {co, s} = ci ? w_r1 : w_r0;

  // The carry into the top bit is recovered from the top sum bit and its operands.
  assign c_msb = s[BLOCK-1] ^ a[BLOCK-1] ^ b[BLOCK-1];

endmodule

// File: rtl/csel_pipe_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready handshake.
// Stage k resolves blocks k*BPS .. min((k+1)*BPS,NB)-1 using the carry
// registered by stage k-1; the whole pipeline stalls together when the
// output holds a result the consumer has not taken.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready = ~out_valid | out_ready)
//   a, b, cin, sub       : operands, carry-in (ignored when sub), subtract select
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : result, carry out (no-borrow when sub), signed overflow
module csel_pipe_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = CSEL_DEF_WIDTH,
  parameter int BLOCK = CSEL_DEF_BLOCK,
  parameter int BPS   = CSEL_DEF_BPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NB = csel_num_blocks(WIDTH, BLOCK);
  localparam int NS = csel_num_stages(WIDTH, BLOCK, BPS);

  if (WIDTH % BLOCK != 0) begin : g_bad_width
    $error("csel_pipe_adder: WIDTH must be a multiple of BLOCK");
  end
  if (BPS < 1) begin : g_bad_bps
    $error("csel_pipe_adder: BPS must be at least 1");
  end

  // Per-stage registers; index k is the register set at the end of stage k.
  logic [WIDTH-1:0] r_a    [NS];
  logic [WIDTH-1:0] r_b    [NS];
  logic [WIDTH-1:0] r_sum  [NS];
  logic             r_c    [NS];
  logic             r_cmsb [NS];
  logic             r_vld  [NS];

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  assign w_b_eff   = b ^ {WIDTH{sub}};
  assign w_cin_eff = sub | cin;

  for (genvar s = 0; s < NS; s++) begin : g_stage
    localparam int LO  = s * BPS;
    localparam int HI  = ((s + 1) * BPS < NB) ? (s + 1) * BPS : NB;
    localparam int NBS = HI - LO;

    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_sum_in;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_ci_in;
    logic             w_vld_in;
    logic [NBS:0]     w_c;
    logic [NBS-1:0]   w_cm;
    logic [BLOCK-1:0] w_s [NBS];

    // ---- stage input: ports for stage 0, previous register set otherwise ----
    if (s == 0) begin : g_src
      assign w_a_in   = a;
      assign w_b_in   = w_b_eff;
      assign w_sum_in = '0;
      assign w_ci_in  = w_cin_eff;
      assign w_vld_in = in_valid;
    end else begin : g_src
      assign w_a_in   = r_a[s-1];
      assign w_b_in   = r_b[s-1];
      assign w_sum_in = r_sum[s-1];
      assign w_ci_in  = r_c[s-1];
      assign w_vld_in = r_vld[s-1];
    end

    assign w_c[0] = w_ci_in;

    for (genvar j = 0; j < NBS; j++) begin : g_blk
      csel_block #(.BLOCK(BLOCK)) u_blk (
        .a     (w_a_in[(LO + j) * BLOCK +: BLOCK]),
        .b     (w_b_in[(LO + j) * BLOCK +: BLOCK]),
        .ci    (w_c[j]),
        .s     (w_s[j]),
        .co    (w_c[j + 1]),
        .c_msb (w_cm[j])
      );
    end

    // Resolved sum so far: earlier stages' bits pass through, this stage's
    // blocks overwrite their slices; higher slices are don't-care.
    always_comb begin
      w_sum_nxt = w_sum_in;
      for (int i = 0; i < NBS; i++) begin
        w_sum_nxt[(LO + i) * BLOCK +: BLOCK] = w_s[i];
      end
    end

    // ---- stage register boundary ----
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld[s] <= 1'b0;
      end else if (w_adv) begin
        r_vld[s] <= w_vld_in;
      end
    end

    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_a[s] <= w_a_in;
        r_b[s] <= w_b_in;
      end
    end

    if (s == NS - 1) begin : g_last
      // The final register set drives the outputs, so it is cleared on reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sum[s]  <= '0;
          r_c[s]    <= 1'b0;
          r_cmsb[s] <= 1'b0;
        end else if (w_adv) begin
          r_sum[s]  <= w_sum_nxt;
          r_c[s]    <= w_c[NBS];
          r_cmsb[s] <= w_cm[NBS-1];
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_sum[s]  <= w_sum_nxt;
          r_c[s]    <= w_c[NBS];
          r_cmsb[s] <= w_cm[NBS-1];
        end
      end
    end
  end

  // ---- output boundary ----
  assign out_valid = r_vld[NS-1];
  assign sum       = r_sum[NS-1];
  assign cout      = r_c[NS-1];
  assign ovf       = r_cmsb[NS-1] ^ r_c[NS-1];

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Bench for csel_pipe_adder: a 16-bit/BLOCK4/BPS2 instance for directed,
// backpressure and reset scenarios, plus three 32-bit instances (BPS 1, 3, 8)
// fed a shared random stream. Expected results come from an integer model.
module tb_csel_pipe_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        m_iv, m_cin, m_sub, m_ordy;
  logic [15:0] m_a, m_b, m_sum;
  logic        s_iv, s_cin, s_sub;
  logic [31:0] s_a, s_b;

  logic        o_ov   [N];
  logic        o_ir   [N];
  logic        o_cout [N];
  logic        o_ovf  [N];
  logic [31:0] o_sum  [N];

  exp_t q [N][$];
  bit   seen [N];
  bit   main_lat_chk;
  bit   use_exp;
  exp_t dexp;
  bit   m_acc, s_acc;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  csel_pipe_adder #(.WIDTH(16), .BLOCK(4), .BPS(2)) u_main (
    .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(o_ir[0]), .a(m_a), .b(m_b),
    .cin(m_cin), .sub(m_sub), .out_valid(o_ov[0]), .out_ready(m_ordy), .sum(m_sum),
    .cout(o_cout[0]), .ovf(o_ovf[0]));
  assign o_sum[0] = {16'h0, m_sum};

  csel_pipe_adder #(.WIDTH(32), .BLOCK(4), .BPS(1)) u_bps1 (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(o_ir[1]), .a(s_a), .b(s_b),
    .cin(s_cin), .sub(s_sub), .out_valid(o_ov[1]), .out_ready(1'b1), .sum(o_sum[1]),
    .cout(o_cout[1]), .ovf(o_ovf[1]));

  csel_pipe_adder #(.WIDTH(32), .BLOCK(4), .BPS(3)) u_bps3 (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(o_ir[2]), .a(s_a), .b(s_b),
    .cin(s_cin), .sub(s_sub), .out_valid(o_ov[2]), .out_ready(1'b1), .sum(o_sum[2]),
    .cout(o_cout[2]), .ovf(o_ovf[2]));

  csel_pipe_adder #(.WIDTH(32), .BLOCK(4), .BPS(8)) u_bps8 (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(o_ir[3]), .a(s_a), .b(s_b),
    .cin(s_cin), .sub(s_sub), .out_valid(o_ov[3]), .out_ready(1'b1), .sum(o_sum[3]),
    .cout(o_cout[3]), .ovf(o_ovf[3]));

  function automatic int lat(input int k);
    case (k)
      0:       return 2;
      1:       return 8;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    longint full, half, ua, ub, r, sa, sb, rs;
    logic [63:0] rv;
    full = longint'(1) << w;
    half = full / 2;
    ua = longint'(a) & (full - 1);
    ub = longint'(b) & (full - 1);
    r  = sub ? (ua - ub) : (ua + ub + longint'(cin));
    rv = 64'(r & (full - 1));
    e.sum  = rv[31:0];
    e.cout = sub ? (ua >= ub) : (r >= full);
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    rs = sub ? (sa - sb) : (sa + sb + longint'(cin));
    e.ovf = (rs >= half) || (rs < -half);
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < N; k++) n += q[k].size();
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out(input int k);
    exp_t e;
    if (o_ov[k]) begin
      chk($sformatf("unexpected_out[%0d]", k), 64'(q[k].size() != 0), 64'd1);
      if (q[k].size() != 0) begin
        e = q[k][0];
        chk($sformatf("result[%0d]", k), {o_sum[k], o_cout[k], o_ovf[k]}, {e.sum, e.cout, e.ovf});
        if (!seen[k] && (k != 0 || main_lat_chk))
          chk($sformatf("latency[%0d]", k), 64'(cyc - e.acc), 64'(lat(k)));
        seen[k] = 1'b1;
      end
    end
  endtask

  // Called at posedge+1 with this cycle's inputs applied; returns at next posedge+1.
  task automatic cycle();
    exp_t e;
    #4;
    m_acc = 1'b0;
    s_acc = 1'b0;
    if (!rst) begin
      chk("in_ready", 64'(o_ir[0]), 64'(!o_ov[0] || m_ordy));
      if (m_iv && o_ir[0]) begin
        e = use_exp ? dexp : model(16, 32'(m_a), 32'(m_b), m_cin, m_sub);
        e.acc = cyc;
        q[0].push_back(e);
        m_acc = 1'b1;
      end
      if (s_iv) begin
        s_acc = 1'b1;
        for (int k = 1; k < N; k++) begin
          if (o_ir[k]) begin
            e = model(32, s_a, s_b, s_cin, s_sub);
            e.acc = cyc;
            q[k].push_back(e);
          end else begin
            s_acc = 1'b0;
          end
        end
      end
      if (o_ov[0] && m_ordy && q[0].size() != 0) begin
        void'(q[0].pop_front());
        seen[0] = 1'b0;
      end
      for (int k = 1; k < N; k++) begin
        if (o_ov[k] && q[k].size() != 0) begin
          void'(q[k].pop_front());
          seen[k] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) check_out(k);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_pending", 64'(pending()), 64'd0);
  endtask

  task automatic send_dir(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic [15:0] esum, input logic ecout,
                          input logic eovf);
    m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_iv = 1'b1;
    use_exp = 1'b1;
    dexp.sum = {16'h0, esum}; dexp.cout = ecout; dexp.ovf = eovf; dexp.acc = 0;
    cycle();
    m_iv = 1'b0;
    use_exp = 1'b0;
    drain(10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, t, s_cnt, guard;
    rst = 1'b1;
    m_iv = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_ordy = 1'b1;
    s_iv = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
    use_exp = 1'b0; main_lat_chk = 1'b1;
    dexp.sum = '0; dexp.cout = 1'b0; dexp.ovf = 1'b0; dexp.acc = 0;
    for (int k = 0; k < N; k++) seen[k] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", 64'(o_ov[0]), 64'd0);
    chk("rst_sum", 64'(o_sum[0]), 64'd0);
    chk("rst_cout_ovf", {62'd0, o_cout[0], o_ovf[0]}, 64'd0);
    chk("rst_in_ready", 64'(o_ir[0]), 64'd1);
    chk("rst_sweep_valid", {61'd0, o_ov[1], o_ov[2], o_ov[3]}, 64'd0);

    // Directed cases on the 16-bit instance
    send_dir(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    send_dir(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    send_dir(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_dir(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_dir(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Backpressure: five back-to-back ops, consumer stalls 3 cycles mid-stream
    main_lat_chk = 1'b0;
    sent = 0;
    t = 0;
    while (sent < 5 && t < 50) begin
      m_a = 16'($urandom); m_b = 16'($urandom);
      m_cin = 1'($urandom); m_sub = 1'($urandom);
      m_iv = 1'b1;
      m_ordy = !(t >= 3 && t < 6);
      cycle();
      if (m_acc) sent++;
      t++;
    end
    m_iv = 1'b0;
    m_ordy = 1'b1;
    chk("bp_sent", 64'(sent), 64'd5);
    drain(20);

    // Reset while two ops are in flight
    main_lat_chk = 1'b1;
    m_a = 16'($urandom); m_b = 16'($urandom); m_cin = 1'b0; m_sub = 1'b0; m_iv = 1'b1;
    cycle();
    m_a = 16'($urandom); m_b = 16'($urandom);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    m_iv = 1'b0;
    for (int k = 0; k < N; k++) begin
      q[k].delete();
      seen[k] = 1'b0;
    end
    chk("midrst_out_valid", 64'(o_ov[0]), 64'd0);
    chk("midrst_sum", 64'(o_sum[0]), 64'd0);
    chk("midrst_in_ready", 64'(o_ir[0]), 64'd1);
    repeat (6) cycle();

    // Random traffic: main with random valid/ready, sweep instances always ready
    main_lat_chk = 1'b0;
    s_cnt = 0;
    guard = 0;
    while (s_cnt < 1000 && guard < 5000) begin
      m_iv = ($urandom_range(0, 3) != 0);
      m_a = 16'(pick32()); m_b = 16'(pick32());
      m_cin = 1'($urandom); m_sub = 1'($urandom);
      m_ordy = ($urandom_range(0, 3) != 0);
      s_iv = ($urandom_range(0, 7) != 0);
      s_a = pick32(); s_b = pick32();
      s_cin = 1'($urandom); s_sub = 1'($urandom);
      cycle();
      if (s_acc) s_cnt++;
      guard++;
    end
    m_iv = 1'b0;
    s_iv = 1'b0;
    m_ordy = 1'b1;
    chk("sweep_count", 64'(s_cnt), 64'd1000);
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
